// File: rtl/dpram_hs_sc.sv
// Single-clock dual-port RAM (1W/1R) with valid/ready handshakes, self-clearing init and registered read response.
// Optional DPRAM_HS_BYPASS_EN: same-address read/write collision returns the new write data instead of the old word.
`timescale 1ns/1ps
module dpram_hs_sc #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 10,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic wr_fire;
    logic rd_fire;
    logic clr_wr;

    assign wr_ready = init_done;
    assign rd_ready = init_done && (!rsp_valid || rsp_ready);
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_valid && rd_ready;
    assign clr_wr   = (state == CLEAR);

    // Clear sequencer: one word per cycle, last word written on the cycle that enters RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + ADDR_W'(1);
                    if (clr_addr == {ADDR_W{1'b1}}) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state     <= CLEAR;
                    clr_addr  <= '0;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

    // Storage carries no reset so it maps onto RAM macros; the sequencer provides the clear.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[clr_addr] <= INIT_VAL;
        end else if (wr_fire) begin
            mem[wr_addr] <= wr_data;
        end
    end

    logic [DATA_W-1:0] rd_word;
`ifdef DPRAM_HS_BYPASS_EN
    assign rd_word = (wr_fire && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
`else
    assign rd_word = mem[rd_addr];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (rd_fire) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rd_word;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dpram_hs_sc.sv
// Directed bench for dpram_hs_sc: init timing, read/write, collision, backpressure hold, reset mid-operation.
`timescale 1ns/1ps
module tb_dpram_hs_sc;

    logic       clk;
    logic       rst;
    logic       init_done;
    logic       wr_valid;
    logic       wr_ready;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [9:0] rd_addr;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;

    int n_checks = 0;
    int n_errors = 0;

    dpram_hs_sc #(
        .DATA_W   (8),
        .ADDR_W   (10),
        .INIT_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges from release of reset until init_done; ready must stay low meanwhile.
    task automatic wait_init(input string tag);
        int   cnt;
        logic early;
        cnt   = 0;
        early = 1'b0;
        while (cnt < 1100) begin
            step();
            cnt++;
            if (init_done) break;
            if (wr_ready || rd_ready) early = 1'b1;
        end
        check({tag, "_init_cycles"}, cnt, 1024);
        check({tag, "_ready_in_clear"}, {31'd0, early}, 0);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [9:0] a, input logic [7:0] exp);
        rd_valid = 1'b1;
        rd_addr  = a;
        step();
        rd_valid = 1'b0;
        check({tag, "_vld"}, {31'd0, rsp_valid}, 1);
        check({tag, "_dat"}, {24'd0, rsp_data}, {24'd0, exp});
        step();
    endtask

    initial begin
        logic [7:0] coll_exp;
`ifdef DPRAM_HS_BYPASS_EN
        coll_exp = 8'h3C;
`else
        coll_exp = 8'h00;
`endif
        rst       = 1'b1;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_valid  = 1'b0;
        rd_addr   = '0;
        rsp_ready = 1'b1;

        // Reset state and init timing
        step();
        step();
        check("rst_init_done", {31'd0, init_done}, 0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        check("rst_rsp_data", {24'd0, rsp_data}, 0);
        check("rst_wr_ready", {31'd0, wr_ready}, 0);
        check("rst_rd_ready", {31'd0, rd_ready}, 0);
        rst = 1'b0;
        wait_init("t1");
        check("t1_wr_ready", {31'd0, wr_ready}, 1);
        check("t1_rd_ready", {31'd0, rd_ready}, 1);

        // Read of an unwritten word returns INIT_VAL
        do_read("t2_rd5", 10'd5, 8'h00);
        check("t2_rsp_clr", {31'd0, rsp_valid}, 0);

        // Write then read, then back-to-back reads
        do_write(10'd5, 8'hA5);
        do_read("t3_rd5", 10'd5, 8'hA5);
        rd_valid = 1'b1;
        rd_addr  = 10'd5;
        step();
        check("t3_b2b_a_vld", {31'd0, rsp_valid}, 1);
        check("t3_b2b_a_dat", {24'd0, rsp_data}, 32'hA5);
        rd_addr = 10'd6;
        step();
        rd_valid = 1'b0;
        check("t3_b2b_b_vld", {31'd0, rsp_valid}, 1);
        check("t3_b2b_b_dat", {24'd0, rsp_data}, 32'h00);
        step();
        check("t3_b2b_drain", {31'd0, rsp_valid}, 0);

        // Same-address collision
        wr_valid = 1'b1;
        wr_addr  = 10'd10;
        wr_data  = 8'h3C;
        rd_valid = 1'b1;
        rd_addr  = 10'd10;
        step();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        check("t4_coll_vld", {31'd0, rsp_valid}, 1);
        check("t4_coll_dat", {24'd0, rsp_data}, {24'd0, coll_exp});
        step();
        do_read("t4_rd10", 10'd10, 8'h3C);

        // Backpressure hold with a competing request waiting
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        rd_addr   = 10'd5;
        step();
        rd_addr = 10'd6;
        for (int i = 0; i < 3; i++) begin
            check("t5_hold_vld", {31'd0, rsp_valid}, 1);
            check("t5_hold_dat", {24'd0, rsp_data}, 32'hA5);
            check("t5_hold_rd_ready", {31'd0, rd_ready}, 0);
            step();
        end
        check("t5_hold_vld_end", {31'd0, rsp_valid}, 1);
        check("t5_hold_dat_end", {24'd0, rsp_data}, 32'hA5);
        rsp_ready = 1'b1;
        #1;
        check("t5_rd_ready_comb", {31'd0, rd_ready}, 1);
        step();
        rd_valid = 1'b0;
        check("t5_next_vld", {31'd0, rsp_valid}, 1);
        check("t5_next_dat", {24'd0, rsp_data}, 32'h00);
        step();
        check("t5_drain", {31'd0, rsp_valid}, 0);

        // Reset during RUN with a pending response
        do_write(10'd5, 8'hA5);
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        rd_addr   = 10'd5;
        step();
        rd_valid = 1'b0;
        check("t6_pend_vld", {31'd0, rsp_valid}, 1);
        rst = 1'b1;
        step();
        check("t6_run_rst_vld", {31'd0, rsp_valid}, 0);
        check("t6_run_rst_done", {31'd0, init_done}, 0);
        check("t6_run_rst_rd_ready", {31'd0, rd_ready}, 0);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        wait_init("t6_run");
        do_read("t6_run_rd5", 10'd5, 8'h00);

        // Reset at cycle 100 of CLEAR
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) step();
        check("t6_clr_mid_done", {31'd0, init_done}, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_init("t6_clr");
        do_read("t6_clr_rd5", 10'd5, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
